// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the instruction loader state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } load_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready channel from the host/boot interface into the loader.
interface instr_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/isa_legal_check.sv
// Combinational check of a 32-bit word against the supported MIPS subset.
module isa_legal_check
    import mips_pkg::*;
(
    input  logic [31:0] word,
    output logic        legal
);

    always_comb begin
        legal = 1'b0;
        case (word[31:26])
            OP_LW, OP_SW, OP_LUI, OP_ORI, OP_ADDIU, OP_BEQ, OP_J: legal = 1'b1;
            OP_RTYPE: begin
                case (word[5:0])
                    FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    // funct 0 is only acceptable as the canonical all-zero NOP
                    default: legal = (word == 32'h0000_0000);
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to
// instruction memory, flagging the first unsupported word and overflow.
module instr_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_loader_if.slave     in_if,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              illegal,
    output logic [ADDR_W-1:0] illegal_addr,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    load_state_e       state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              illegal_q, illegal_d;
    logic [ADDR_W-1:0] illegal_addr_q, illegal_addr_d;
    logic              overflow_q, overflow_d;
    logic              word_legal;

    isa_legal_check u_legal (
        .word  (word_q),
        .legal (word_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            last_q         <= 1'b0;
            ptr_q          <= '0;
            word_count_q   <= '0;
            illegal_q      <= 1'b0;
            illegal_addr_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            last_q         <= last_d;
            ptr_q          <= ptr_d;
            word_count_q   <= word_count_d;
            illegal_q      <= illegal_d;
            illegal_addr_q <= illegal_addr_d;
            overflow_q     <= overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        last_d         = last_q;
        ptr_d          = ptr_q;
        word_count_d   = word_count_q;
        illegal_d      = illegal_q;
        illegal_addr_d = illegal_addr_q;
        overflow_d     = overflow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_LOAD;
                    byte_cnt_d     = '0;
                    word_d         = '0;
                    last_d         = 1'b0;
                    ptr_d          = '0;
                    word_count_d   = '0;
                    illegal_d      = 1'b0;
                    illegal_addr_d = '0;
                    overflow_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_if.in_valid) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[31:24] = in_if.in_data;
                        2'd1:    word_d[23:16] = in_if.in_data;
                        2'd2:    word_d[15:8]  = in_if.in_data;
                        default: word_d[7:0]   = in_if.in_data;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3 || in_if.in_last) begin
                        state_d = ST_WRITE;
                        last_d  = in_if.in_last;
                    end
                end
            end
            ST_WRITE: begin
                ptr_d        = ptr_q + 1'b1;
                word_count_d = word_count_q + 1'b1;
                byte_cnt_d   = '0;
                word_d       = '0;
                last_d       = 1'b0;
                if (!word_legal && !illegal_q) begin
                    illegal_d      = 1'b1;
                    illegal_addr_d = ptr_q;
                end
                // a program ending exactly at DEPTH is a clean finish, not overflow
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (word_count_d == DEPTH_CNT) begin
                    state_d    = ST_DONE;
                    overflow_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_if.in_ready = (state_q == ST_LOAD);
    assign imem_we        = (state_q == ST_WRITE);
    assign imem_addr      = ptr_q;
    assign imem_wdata     = word_q;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done           = (state_q == ST_DONE);
    assign word_count     = word_count_q;
    assign illegal        = illegal_q;
    assign illegal_addr   = illegal_addr_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Produces the instruction stream that the control unit decodes: it receives a program as a byte stream over a valid/ready handshake.
- Assembles bytes big-endian into 32-bit MIPS words and writes each word into instruction memory at consecutive word addresses.
- Checks every word against the supported opcode/funct set and flags the first unsupported word.
- Sits between the host/boot interface and the instruction memory write port, and is active only before the CPU runs.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, number of instruction memory words (DEPTH <= 2**ADDR_W)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load at word address 0
in_valid  input  1  in_data holds a valid byte
in_data  input  8  program byte, most significant byte of each word first
in_last  input  1  qualifies the final byte of the program (sampled with in_valid)
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable (one-cycle pulse)
imem_addr  output  ADDR_W  word address to write
imem_wdata  output  32  assembled instruction word
busy  output  1  load in progress
done  output  1  load finished; held until next start
word_count  output  ADDR_W+1  words written in the current load
illegal  output  1  sticky; an unsupported instruction was written
illegal_addr  output  ADDR_W  word address of the first unsupported word
overflow  output  1  sticky; program exceeded DEPTH words

Behaviour:
- Reset (async, active-high): state IDLE; every output 0; byte counter, pointer and assembly register cleared. Reset during a load aborts it. The partially assembled word is dropped, and words already written are not rolled back.
- FSM states:
  - IDLE: in_ready=0.
  - On start, go to LOAD. Clear ptr, word_count, illegal, illegal_addr, overflow and done.
  - LOAD: in_ready=1, busy=1. A byte is accepted when in_valid && in_ready.
  - Byte k (k=0..3) goes into word bits [31-8k -: 8].
  - Accepting byte 3, or any byte with in_last=1, moves to WRITE the next cycle with in_ready=0.
  - When in_last ends a partial word, the unfilled low bytes are 0.
  - WRITE (exactly one cycle): imem_we=1, imem_addr=ptr, imem_wdata=assembled word, busy=1.
  - At the end of WRITE: ptr and word_count increment, and the byte counter and assembly register clear.
  - Next state after WRITE:
    - DONE if the word was ended by in_last.
    - DONE with overflow=1 if word_count has reached DEPTH without in_last.
    - Otherwise LOAD.
  - DONE: done=1, busy=0, in_ready=0. start re-enters LOAD with the same clears as from IDLE.
- start while busy is ignored.
- Latency: the imem write occurs the cycle after the 4th accepted byte. Sustained throughput is 4 bytes per 5 cycles.
- Bytes presented in WRITE or DONE are not accepted (in_ready=0). After overflow the host's remaining bytes stay unconsumed.
- Legality check on each word in WRITE:
  - Legal opcodes: 100011 LW, 101011 SW, 001111 LUI, 001101 ORI, 001001 ADDIU, 000100 BEQ, 000010 J.
  - Opcode 000000 is legal only with funct 100000, 100001, 100010, 100100, 100101 or 101010.
  - The all-zero word (NOP) is legal.
  - The first illegal word sets illegal=1 and latches illegal_addr=ptr. Later illegal words do not change illegal_addr.
  - Illegal words are still written.
- Partial-word padding is applied before the legality check.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_LUI, OP_ORI, OP_ADDIU, OP_BEQ, OP_J.
  - Funct constants FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_SLT.
  - The loader state enum.
- The control unit is moved onto the same constants.
- Sub-module isa_legal_check: combinational; input word[31:0], output legal. This keeps the decode in one place for the control unit and its future illegal-instruction trap.

Test Plan:
- Load 8 bytes 8C 01 00 04 / 08 00 00 00, in_last on byte 8 → writes addr0=0x8C010004 and addr1=0x08000000; done=1, word_count=2, illegal=0.
- Stream with in_valid toggling every other cycle → the same words are written. in_ready is 0 during each WRITE cycle, and no byte is lost or duplicated.
- Words 0x00000000 then 0xFC000000 then 0x0000001F → all 3 are written; illegal=1 and illegal_addr=1, not moved by addr2.
- 6 bytes 34 21 12 34 AB CD with in_last on CD → addr1=0xABCD0000, word_count=2.
- DEPTH=4 with 20 bytes and no in_last → 4 words written, overflow=1, done=1; in_ready stays 0 afterwards.
- reset asserted after 2 bytes of word 1 → all outputs 0 immediately, with no write of the partial word. A new start loads again from addr 0.
